// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard/stall sequencer for a 5-stage latch chain (PC, F/D, D/X, X/M, M/W).
// Produces per-latch enables and load-NOP flush controls from the hazard
// inputs. It covers load-use bubbles, taken-branch squash, multdiv wait and
// external memory wait. It also tracks per-stage valid bits and a saturating
// stall counter for performance reporting.
//
// Parameters:
//   MD_TIMEOUT  cycles allowed in MD_WAIT before the multdiv is abandoned (1..255)
//   CNT_W       width of stall_count
//
// Ports:
//   clk                          system clock, rising edge
//   clr                          asynchronous active-high reset
//   fd_rs1, fd_rs2, fd_uses_rs2  source operands of the F/D instruction
//   dx_rd, dx_is_load            destination / load flag of the D/X instruction
//   x_branch_taken               X stage resolved a taken branch this cycle
//   x_md_start                   X stage issues a mult/div this cycle
//   md_ready                     multdiv result valid (single-cycle pulse)
//   ext_stall                    memory not ready, freeze the whole pipe
//   pc_en .. mw_en               latch enables
//   fd_flush, dx_flush, xm_flush latch loads a NOP at the next edge when enabled
//   stage_valid                  [0]=F/D [1]=D/X [2]=X/M [3]=M/W hold real work
//   md_busy                      sequencer is waiting on the multdiv
//   md_error                     sticky multdiv timeout flag
//   stall_count                  saturating count of cycles with pc_en=0
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic             fd_uses_rs2,
    input  logic [4:0]       dx_rd,
    input  logic             dx_is_load,
    input  logic             x_branch_taken,
    input  logic             x_md_start,
    input  logic             md_ready,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic [3:0]       stage_valid,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] timer;
    logic [7:0] next_timer;
    // Set for the one cycle after md_ready, when the multdiv result is
    // written into X/M while the front of the pipe stays frozen.
    logic       md_done;
    logic       next_md_done;
    logic       load_use;
    logic       md_timeout;

    // Register x0 never creates a dependency, so rd=0 is exempt.
    assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                      ((fd_rs1 == dx_rd) || (fd_uses_rs2 && (fd_rs2 == dx_rd)));

    // A timeout needs the latches to move (D/X is discarded), so it is
    // deferred while the memory holds the pipe frozen.
    assign md_timeout = (state == MD_WAIT) && !ext_stall && !md_ready &&
                        (timer >= TIMEOUT_LAST);

    assign md_busy = (state == MD_WAIT);

    // State register, multdiv timer and result-cycle flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= RUN;
            timer   <= 8'd0;
            md_done <= 1'b0;
        end else begin
            state   <= next_state;
            timer   <= next_timer;
            md_done <= next_md_done;
        end
    end

    // Next-state logic
    always_comb begin
        next_state   = state;
        next_timer   = timer;
        next_md_done = md_done;
        case (state)
            RUN: begin
                if (md_done) begin
                    if (!ext_stall) begin
                        next_md_done = 1'b0;
                    end
                end else if (!ext_stall && x_md_start) begin
                    next_state = MD_WAIT;
                    next_timer = 8'd0;
                end
            end
            MD_WAIT: begin
                // The timer keeps running even under ext_stall; it saturates
                // so a very long memory stall cannot wrap it.
                if (timer != 8'hFF) begin
                    next_timer = timer + 8'd1;
                end
                // md_ready is a pulse, so it is taken even during ext_stall.
                if (md_ready) begin
                    next_state   = RUN;
                    next_md_done = 1'b1;
                end else if (md_timeout) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // Output logic: enables and flushes follow the current inputs in the same cycle
    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_en    = 1'b0;
        xm_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        if (!clr) begin
            case (state)
                RUN: begin
                    if (ext_stall) begin
                        pc_en = 1'b0;
                    end else if (md_done) begin
                        dx_en = 1'b1;
                        xm_en = 1'b1;
                        mw_en = 1'b1;
                    end else if (x_md_start) begin
                        pc_en    = 1'b1;
                        fd_en    = 1'b1;
                        dx_en    = 1'b1;
                        xm_en    = 1'b1;
                        mw_en    = 1'b1;
                        xm_flush = 1'b1;
                        fd_flush = x_branch_taken;
                        dx_flush = x_branch_taken;
                    end else if (x_branch_taken) begin
                        pc_en    = 1'b1;
                        fd_en    = 1'b1;
                        dx_en    = 1'b1;
                        xm_en    = 1'b1;
                        mw_en    = 1'b1;
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (load_use) begin
                        dx_en    = 1'b1;
                        dx_flush = 1'b1;
                        xm_en    = 1'b1;
                        mw_en    = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        fd_en = 1'b1;
                        dx_en = 1'b1;
                        xm_en = 1'b1;
                        mw_en = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!ext_stall) begin
                        // Bubbles drain into M while the front waits.
                        xm_en    = 1'b1;
                        xm_flush = 1'b1;
                        mw_en    = 1'b1;
                        if (md_timeout) begin
                            dx_en    = 1'b1;
                            dx_flush = 1'b1;
                        end
                    end
                end
                default: pc_en = 1'b0;
            endcase
        end
    end

    // Sticky timeout flag, valid bits and stall counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            md_error    <= 1'b0;
            stage_valid <= 4'b0000;
            stall_count <= '0;
        end else begin
            if (md_timeout) begin
                md_error <= 1'b1;
            end
            if (fd_en) begin
                stage_valid[0] <= !fd_flush;
            end
            if (dx_en) begin
                stage_valid[1] <= stage_valid[0] && !dx_flush;
            end
            if (xm_en) begin
                stage_valid[2] <= stage_valid[1] && !xm_flush;
            end
            if (mw_en) begin
                stage_valid[3] <= stage_valid[2];
            end
            if (!pc_en && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl. Two instances share every input:
// dut_a uses the default parameters, and dut_b uses MD_TIMEOUT=4 and a 3-bit
// stall counter, so the timeout and saturation corners are reached quickly.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] fd_rs1;
    logic [4:0] fd_rs2;
    logic       fd_uses_rs2;
    logic [4:0] dx_rd;
    logic       dx_is_load;
    logic       x_branch_taken;
    logic       x_md_start;
    logic       md_ready;
    logic       ext_stall;

    logic        a_pc_en, a_fd_en, a_dx_en, a_xm_en, a_mw_en;
    logic        a_fd_flush, a_dx_flush, a_xm_flush;
    logic [3:0]  a_stage_valid;
    logic        a_md_busy, a_md_error;
    logic [15:0] a_stall_count;

    logic        b_pc_en, b_fd_en, b_dx_en, b_xm_en, b_mw_en;
    logic        b_fd_flush, b_dx_flush, b_xm_flush;
    logic [3:0]  b_stage_valid;
    logic        b_md_busy, b_md_error;
    logic [2:0]  b_stall_count;

    logic [4:0] a_en, b_en;
    logic [2:0] a_fl, b_fl;

    int compared   = 0;
    int mismatched = 0;
    logic [3:0] exp_valid;

    assign a_en = {a_pc_en, a_fd_en, a_dx_en, a_xm_en, a_mw_en};
    assign b_en = {b_pc_en, b_fd_en, b_dx_en, b_xm_en, b_mw_en};
    assign a_fl = {a_fd_flush, a_dx_flush, a_xm_flush};
    assign b_fl = {b_fd_flush, b_dx_flush, b_xm_flush};

    pipeline_ctrl dut_a (
        .clk(clk), .clr(clr),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_uses_rs2(fd_uses_rs2),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load),
        .x_branch_taken(x_branch_taken), .x_md_start(x_md_start),
        .md_ready(md_ready), .ext_stall(ext_stall),
        .pc_en(a_pc_en), .fd_en(a_fd_en), .dx_en(a_dx_en), .xm_en(a_xm_en), .mw_en(a_mw_en),
        .fd_flush(a_fd_flush), .dx_flush(a_dx_flush), .xm_flush(a_xm_flush),
        .stage_valid(a_stage_valid), .md_busy(a_md_busy), .md_error(a_md_error),
        .stall_count(a_stall_count)
    );

    pipeline_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .clr(clr),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_uses_rs2(fd_uses_rs2),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load),
        .x_branch_taken(x_branch_taken), .x_md_start(x_md_start),
        .md_ready(md_ready), .ext_stall(ext_stall),
        .pc_en(b_pc_en), .fd_en(b_fd_en), .dx_en(b_dx_en), .xm_en(b_xm_en), .mw_en(b_mw_en),
        .fd_flush(b_fd_flush), .dx_flush(b_dx_flush), .xm_flush(b_xm_flush),
        .stage_valid(b_stage_valid), .md_busy(b_md_busy), .md_error(b_md_error),
        .stall_count(b_stall_count)
    );

    always #5 clk = ~clk;

    // Drives every hazard input in one call
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic uses2, input logic [4:0] rd,
                                 input logic is_load, input logic br,
                                 input logic md_start, input logic md_rdy,
                                 input logic ext);
        fd_rs1         = rs1;
        fd_rs2         = rs2;
        fd_uses_rs2    = uses2;
        dx_rd          = rd;
        dx_is_load     = is_load;
        x_branch_taken = br;
        x_md_start     = md_start;
        md_ready       = md_rdy;
        ext_stall      = ext;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compares one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1;
        idle();
        #12;
        checkOutput("reset_en", 32'(a_en), 32'h00);
        checkOutput("reset_flush", 32'(a_fl), 32'h0);
        checkOutput("reset_valid", 32'(a_stage_valid), 32'h0);
        checkOutput("reset_count", 32'(a_stall_count), 32'h0);
        checkOutput("reset_busy", 32'(a_md_busy), 32'h0);
        checkOutput("reset_error", 32'(a_md_error), 32'h0);

        clr = 1'b0;
        #1;
        checkOutput("idle_en", 32'(a_en), 32'h1F);

        // Valid bits fill in from the front, one stage per cycle
        exp_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            exp_valid = {exp_valid[2:0], 1'b1};
            checkOutput($sformatf("fill_valid_%0d", i), 32'(a_stage_valid), 32'(exp_valid));
        end
        checkOutput("fill_en", 32'(a_en), 32'h1F);

        // Load-use on rs1
        applyStimulus(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_en", 32'(a_en), 32'h07);
        checkOutput("lu_flush", 32'(a_fl), 32'h2);
        nextCycle();
        idle();
        checkOutput("lu_count", 32'(a_stall_count), 32'd1);
        checkOutput("lu_valid", 32'(a_stage_valid), 32'b1101);

        // rd=0 never stalls; rs2 only counts when it is read
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rd0_en", 32'(a_en), 32'h1F);
        applyStimulus(5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rs2_unused_en", 32'(a_en), 32'h1F);
        applyStimulus(5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rs2_used_en", 32'(a_en), 32'h07);
        idle();
        repeat (4) nextCycle();
        checkOutput("refill_valid", 32'(a_stage_valid), 32'b1111);

        // Taken branch squashes F/D and D/X
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br_en", 32'(a_en), 32'h1F);
        checkOutput("br_flush", 32'(a_fl), 32'h6);
        nextCycle();
        idle();
        checkOutput("br_valid", 32'(a_stage_valid), 32'b1100);
        repeat (4) nextCycle();

        // Multdiv with md_ready in the 10th wait cycle
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("md_start_en", 32'(a_en), 32'h1F);
        checkOutput("md_start_flush", 32'(a_fl), 32'h1);
        nextCycle();
        idle();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            #1;
            checkOutput($sformatf("md_wait_busy_%0d", k), 32'(a_md_busy), 32'h1);
            checkOutput($sformatf("md_wait_en_%0d", k), 32'(a_en), 32'h03);
            checkOutput($sformatf("md_wait_flush_%0d", k), 32'(a_fl), 32'h1);
            nextCycle();
            idle();
        end
        #1;
        checkOutput("md_result_busy", 32'(a_md_busy), 32'h0);
        checkOutput("md_result_en", 32'(a_en), 32'h07);
        checkOutput("md_result_flush", 32'(a_fl), 32'h0);
        nextCycle();
        checkOutput("md_after_en", 32'(a_en), 32'h1F);
        checkOutput("md_count", 32'(a_stall_count), 32'd12);
        checkOutput("md_b_error", 32'(b_md_error), 32'h1);

        // ext_stall overrides a load-use hazard
        applyStimulus(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("ext_lu_en", 32'(a_en), 32'h00);
        checkOutput("ext_lu_flush", 32'(a_fl), 32'h0);
        nextCycle();
        idle();
        checkOutput("ext_lu_count", 32'(a_stall_count), 32'd13);

        // ext_stall inside MD_WAIT, then clr pulsed mid-wait
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("ext_md_en", 32'(a_en), 32'h00);
        checkOutput("ext_md_flush", 32'(a_fl), 32'h0);
        checkOutput("ext_md_busy", 32'(a_md_busy), 32'h1);
        nextCycle();
        checkOutput("ext_md_count", 32'(a_stall_count), 32'd14);
        clr = 1'b1;
        #1;
        checkOutput("clr_md_busy", 32'(a_md_busy), 32'h0);
        checkOutput("clr_md_count", 32'(a_stall_count), 32'h0);
        checkOutput("clr_md_valid", 32'(a_stage_valid), 32'h0);
        checkOutput("clr_md_en", 32'(a_en), 32'h00);
        checkOutput("clr_b_error", 32'(b_md_error), 32'h0);
        clr = 1'b0;
        idle();
        #1;
        checkOutput("post_clr_en", 32'(a_en), 32'h1F);

        // Timeout on dut_b (MD_TIMEOUT=4); dut_a keeps waiting
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        idle();
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("to_busy_%0d", k), 32'(b_md_busy), 32'h1);
            checkOutput($sformatf("to_en_%0d", k), 32'(b_en), (k == 4) ? 32'h07 : 32'h03);
            checkOutput($sformatf("to_flush_%0d", k), 32'(b_fl), (k == 4) ? 32'h3 : 32'h1);
            nextCycle();
        end
        checkOutput("to_error", 32'(b_md_error), 32'h1);
        checkOutput("to_busy_after", 32'(b_md_busy), 32'h0);
        checkOutput("to_en_after", 32'(b_en), 32'h1F);
        checkOutput("to_b_count", 32'(b_stall_count), 32'd4);
        checkOutput("to_a_error", 32'(a_md_error), 32'h0);
        checkOutput("to_a_busy", 32'(a_md_busy), 32'h1);

        // Stall counter saturation on the 3-bit instance
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) nextCycle();
        checkOutput("sat_b_count", 32'(b_stall_count), 32'd7);
        checkOutput("sat_a_count", 32'(a_stall_count), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
